// File: rtl/bcd_display_scan.sv
// bcd_display_scan: holds a 4-digit BCD word and time-multiplexes it onto a
// shared 4-bit bus with active-low digit enables, one digit per DIV cycles.
// Loads go to a shadow register and are promoted to the displayed value only
// at the frame boundary, so a frame never mixes old and new digits.
// Optional feature macro: BCD_SCAN_LZB_EN (leading-zero blanking).
module bcd_display_scan #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits_in,
  output logic [3:0]  bcd,
  output logic [3:0]  dig_en,
  output logic        pending
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   shadow_reg;
  logic [15:0]   active_reg;
  logic          pending_reg;
  logic [3:0]    bcd_reg;
  logic [3:0]    dig_en_reg;

  logic          tick;
  logic          boundary;
  logic [3:0]    nib [4];
  logic [3:0]    blank;

  assign tick     = (cnt_reg == CNT_MAX);
  assign boundary = tick && (idx_reg == 2'd3);

  // Per-digit nibble select and blank decision, both from the displayed value
  // so blanking lines up with bcd without extra latency.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign nib[gi] = active_reg[4*gi +: 4];
`ifdef BCD_SCAN_LZB_EN
      if (gi == 0) begin : g_first
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = (active_reg[15:4*gi] == '0);
      end
`else
      assign blank[gi] = 1'b0;
`endif
    end
  endgenerate

  // Prescaler: one tick every DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // Digit index advances once per slot and wraps naturally at 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= 2'd0;
    end else if (tick) begin
      idx_reg <= idx_reg + 2'd1;
    end
  end

  // Double buffer: shadow takes every load, active is refreshed only at the
  // frame boundary; a load on the boundary cycle goes straight to active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg  <= '0;
      active_reg  <= '0;
      pending_reg <= 1'b0;
    end else begin
      if (load) begin
        shadow_reg <= digits_in;
      end
      if (boundary) begin
        if (load) begin
          active_reg <= digits_in;
        end else if (pending_reg) begin
          active_reg <= shadow_reg;
        end
        pending_reg <= 1'b0;
      end else if (load) begin
        pending_reg <= 1'b1;
      end
    end
  end

  // Registered scan outputs derived from the current index and active word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_reg    <= 4'h0;
      dig_en_reg <= 4'b1111;
    end else begin
      bcd_reg    <= nib[idx_reg];
      dig_en_reg <= blank[idx_reg] ? 4'b1111 : ~(4'b0001 << idx_reg);
    end
  end

  assign bcd     = bcd_reg;
  assign dig_en  = dig_en_reg;
  assign pending = pending_reg;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Testbench for bcd_display_scan: DIV=4 instance (u4) for the directed frame
// scenarios and DIV=2 instance (u2) for the minimum-prescaler case. A frame-
// arithmetic model is compared every cycle; literal tables pin the model.
module tb_bcd_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld  [2];
  logic [15:0] din [2];
  logic [3:0]  d_bcd [2];
  logic [3:0]  d_en  [2];
  logic        d_pend [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_display_scan #(.DIV(4)) u4 (
    .clk(clk), .rst(rst), .load(ld[0]), .digits_in(din[0]),
    .bcd(d_bcd[0]), .dig_en(d_en[0]), .pending(d_pend[0])
  );

  bcd_display_scan #(.DIV(2)) u2 (
    .clk(clk), .rst(rst), .load(ld[1]), .digits_in(din[1]),
    .bcd(d_bcd[1]), .dig_en(d_en[1]), .pending(d_pend[1])
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_k    [2];   // clock edges since reset release
  logic [15:0] m_sh   [2];
  logic [15:0] m_act  [2];
  logic        m_pend [2];
  logic [3:0]  e_bcd  [2];
  logic [3:0]  e_en   [2];

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic [3:0] f_bcd(input logic [15:0] act, input int idx);
    logic [15:0] s;
    s = act >> (4 * idx);
    return s[3:0];
  endfunction

  function automatic logic [3:0] f_en(input logic [15:0] act, input int idx);
    logic [3:0] en;
    en = 4'b1111;
    en[idx] = 1'b0;
`ifdef BCD_SCAN_LZB_EN
    if (idx > 0 && (act >> (4 * idx)) == 16'h0) en = 4'b1111;
`endif
    return en;
  endfunction

  // Frame position comes from the edge count: slot = (k/DIV)%4, boundary at
  // the last cycle of each 4*DIV frame.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_k[i] <= 0; m_sh[i] <= '0; m_act[i] <= '0; m_pend[i] <= 1'b0;
        e_bcd[i] <= 4'h0; e_en[i] <= 4'b1111;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_bcd[i] <= f_bcd(m_act[i], (m_k[i] / div_of(i)) % 4);
        e_en[i]  <= f_en(m_act[i], (m_k[i] / div_of(i)) % 4);
        if ((m_k[i] % (4 * div_of(i))) == 4 * div_of(i) - 1) begin
          m_act[i]  <= ld[i] ? din[i] : (m_pend[i] ? m_sh[i] : m_act[i]);
          if (ld[i]) m_sh[i] <= din[i];
          m_pend[i] <= 1'b0;
        end else if (ld[i]) begin
          m_sh[i]   <= din[i];
          m_pend[i] <= 1'b1;
        end
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_bcd inst%0d", i), 16'(d_bcd[i]), 16'(e_bcd[i]));
      chk($sformatf("model_en inst%0d", i), 16'(d_en[i]), 16'(e_en[i]));
      chk($sformatf("model_pending inst%0d", i), 16'(d_pend[i]), 16'(m_pend[i]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wk(input int t);
    int n = 0;
    while (m_k[0] != t && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("wait_timeout", 16'(m_k[0]), 16'(t));
  endtask

  // Frames visible on u4 (edge counts 17..112, 16 edges each), slots 0..3.
  int bcd_tab [6][4] = '{'{4,3,2,1}, '{8,7,6,5}, '{9,9,9,9},
                         '{2,0,1,0}, '{0,5,0,0}, '{0,0,0,0}};
`ifdef BCD_SCAN_LZB_EN
  int en_tab [6][4] = '{'{14,13,11,7}, '{14,13,11,7}, '{14,13,11,7},
                        '{14,13,11,15}, '{14,13,15,15}, '{14,15,15,15}};
`else
  int en_tab [6][4] = '{'{14,13,11,7}, '{14,13,11,7}, '{14,13,11,7},
                        '{14,13,11,7}, '{14,13,11,7}, '{14,13,11,7}};
`endif
  int en2_tab [8] = '{14,14,13,13,11,11,7,7};

  initial begin
    rst = 1'b1;
    ld[0] = 1'b0; ld[1] = 1'b0; din[0] = '0; din[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ld[0] = 1'b1; din[0] = 16'h1234;
    ld[1] = 1'b1; din[1] = 16'h1111;

    for (int e = 1; e <= 112; e++) begin
      wk(e);
      ld[0] = 1'b0; ld[1] = 1'b0;
      case (e)
        21: begin ld[0] = 1'b1; din[0] = 16'h5678; end
        47: begin ld[0] = 1'b1; din[0] = 16'h9999; end
        50: begin ld[0] = 1'b1; din[0] = 16'hAAAA; end
        55: begin ld[0] = 1'b1; din[0] = 16'h0102; end
        66: begin ld[0] = 1'b1; din[0] = 16'h0050; end
        82: begin ld[0] = 1'b1; din[0] = 16'h0000; end
        default: ;
      endcase
      if (e == 1) begin
        chk("release_en", 16'(d_en[0]), 16'h000E);
        chk("release_bcd", 16'(d_bcd[0]), 16'h0000);
        chk("load_pending_u4", 16'(d_pend[0]), 16'h0001);
        chk("load_pending_u2", 16'(d_pend[1]), 16'h0001);
      end
      if (e == 15 || e == 22 || e == 51 || e == 63)
        chk($sformatf("pending_high e%0d", e), 16'(d_pend[0]), 16'h0001);
      if (e == 16 || e == 47 || e == 48 || e == 64)
        chk($sformatf("pending_low e%0d", e), 16'(d_pend[0]), 16'h0000);
      if (e >= 17) begin
        chk($sformatf("frame_bcd e%0d", e), 16'(d_bcd[0]),
            16'(bcd_tab[(e - 17) / 16][((e - 17) / 4) % 4]));
        chk($sformatf("frame_en e%0d", e), 16'(d_en[0]),
            16'(en_tab[(e - 17) / 16][((e - 17) / 4) % 4]));
      end
      if (e >= 9 && e <= 32) begin
        chk($sformatf("div2_bcd e%0d", e), 16'(d_bcd[1]), 16'h0001);
        chk($sformatf("div2_en e%0d", e), 16'(d_en[1]), 16'(en2_tab[(e - 9) % 8]));
      end
    end

    // Mid-scan asynchronous reset with a load outstanding.
    wk(113);
    ld[0] = 1'b1; din[0] = 16'h4321;
    wk(114);
    ld[0] = 1'b0;
    chk("pre_reset_pending", 16'(d_pend[0]), 16'h0001);
    chk("pre_reset_en", 16'(d_en[0]), 16'h000E);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_en", 16'(d_en[0]), 16'h000F);
    chk("async_rst_bcd", 16'(d_bcd[0]), 16'h0000);
    chk("async_rst_pending", 16'(d_pend[0]), 16'h0000);
    chk("async_rst_en_u2", 16'(d_en[1]), 16'h000F);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("held_rst_en", 16'(d_en[0]), 16'h000F);
    @(negedge clk);
    chk("post_rst_en", 16'(d_en[0]), 16'h000E);
    chk("post_rst_bcd", 16'(d_bcd[0]), 16'h0000);
    chk("post_rst_pending", 16'(d_pend[0]), 16'h0000);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
